// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: coalescing line write buffer between the data cache and main memory
// Ports: clk, proc_reset (sync, active-high); cache_mem_* = cache-side line request/response
// (request held until the one-cycle cache_mem_ready); mem_* = memory-side line request/response.
// All outputs are registered.
module dcache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         cache_mem_read,
    input  logic         cache_mem_write,
    input  logic [27:0]  cache_mem_addr,
    input  logic [127:0] cache_mem_wdata,
    output logic [127:0] cache_mem_rdata,
    output logic         cache_mem_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, RESP} state_t;
    state_t         state_q, state_d;
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [27:0]    addr_q [DEPTH];
    logic [27:0]    addr_d [DEPTH];
    logic [127:0]   data_q [DEPTH];
    logic [127:0]   data_d [DEPTH];
    logic           ready_q, ready_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [127:0]   rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [27:0]    mem_addr_q, mem_addr_d;
    logic           hit;
    logic [AW-1:0]  hit_idx, off;
    // A slot is live when its distance from head is below count; coalescing keeps at most one live match.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head_q;
            if (CW'(off) < count_q && addr_q[i] == cache_mem_addr) begin
                hit = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;
        addr_d = addr_q;
        data_d = data_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        mem_read_d = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (cache_mem_read && hit) begin
                    rdata_d = data_q[hit_idx];
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (cache_mem_read) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = cache_mem_addr;
                    state_d = RD_MEM;
                end else if (cache_mem_write && hit) begin
                    data_d[hit_idx] = cache_mem_wdata;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (cache_mem_write && count_q != CW'(DEPTH)) begin
                    addr_d[tail_q] = cache_mem_addr;
                    data_d[tail_q] = cache_mem_wdata;
                    tail_d = tail_q + AW'(1);
                    count_d = count_q + CW'(1);
                    ready_d = 1'b1;
                    state_d = RESP;
                end else if (count_q != '0) begin
                    // Covers both background drain and a write stalled on a full buffer.
                    mem_write_d = 1'b1;
                    mem_addr_d = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                    state_d = WR_MEM;
                end
            end
            RD_MEM: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    rdata_d = mem_rdata;
                    ready_d = 1'b1;
                    state_d = RESP;
                end
            end
            WR_MEM: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    head_d = head_q + AW'(1);
                    count_d = count_q - CW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            addr_q <= '{default: '0};
            data_q <= '{default: '0};
            ready_q <= 1'b0;
            rdata_q <= '0;
            mem_read_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            mem_read_q <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
    assign cache_mem_ready = ready_q;
    assign cache_mem_rdata = rdata_q;
    assign mem_read = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: randomized and directed checks of dcache_write_buffer against a queue-based model
module tb_dcache_write_buffer;
    typedef struct {
        logic [27:0]  a;
        logic [127:0] d;
    } ent_t;
    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         cache_mem_read = 1'b0, cache_mem_write = 1'b0;
    logic [27:0]  cache_mem_addr = '0;
    logic [127:0] cache_mem_wdata = '0;
    logic [127:0] cache_mem_rdata;
    logic         cache_mem_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    int total = 0, bad = 0;
    int mem_lat = 2;
    int n_rd_req = 0, n_wr_req = 0, n_wr_done = 0;
    logic [27:0]  last_wr_a = '0;
    logic [127:0] last_wr_d = '0;
    ent_t exp_q[$];
    logic [127:0] mem_store [logic [27:0]];
    logic [127:0] shadow [logic [27:0]];
    logic         m_wr, m_gone;
    logic [27:0]  m_a;
    logic [127:0] m_d;
    int           m_lat;

    dcache_write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .cache_mem_read(cache_mem_read), .cache_mem_write(cache_mem_write),
        .cache_mem_addr(cache_mem_addr), .cache_mem_wdata(cache_mem_wdata),
        .cache_mem_rdata(cache_mem_rdata), .cache_mem_ready(cache_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mem_val(input logic [27:0] a);
        return mem_store.exists(a) ? mem_store[a] : {4{4'hC, a}};
    endfunction

    // Data a read must return: the pending buffered copy if any, else what memory holds.
    function automatic logic [127:0] model_read(input logic [27:0] a);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].a == a) return exp_q[i].d;
        return mem_val(a);
    endfunction

    function automatic void model_write(input logic [27:0] a, input logic [127:0] d);
        ent_t e;
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].a == a) begin
                exp_q[i].d = d;
                return;
            end
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endfunction

    // Memory model: serves one request at a time with mem_lat wait cycles (random if negative).
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!proc_reset && (mem_read || mem_write)) begin
                m_wr = mem_write;
                m_a = mem_addr;
                m_d = mem_wdata;
                if (m_wr) begin
                    n_wr_req++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL drain_unexpected got addr=%h exp no pending entry", m_a);
                    end else if (exp_q[0].a !== m_a || exp_q[0].d !== m_d) begin
                        bad++;
                        $display("FAIL drain_head got addr=%h data=%h exp addr=%h data=%h", m_a, m_d, exp_q[0].a, exp_q[0].d);
                    end
                end else n_rd_req++;
                m_lat = mem_lat < 0 ? int'($urandom_range(0, 4)) : mem_lat;
                m_gone = 1'b0;
                for (int k = 0; k < m_lat; k++) begin
                    @(negedge clk);
                    if (proc_reset || !(mem_read || mem_write)) begin
                        m_gone = 1'b1;
                        break;
                    end
                    total++;
                    if (mem_addr !== m_a || (m_wr && mem_wdata !== m_d)) begin
                        bad++;
                        $display("FAIL mem_hold got addr=%h data=%h exp addr=%h data=%h", mem_addr, mem_wdata, m_a, m_d);
                    end
                end
                if (!m_gone) begin
                    if (m_wr) begin
                        mem_store[m_a] = m_d;
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        n_wr_done++;
                        last_wr_a = m_a;
                        last_wr_d = m_d;
                    end else mem_rdata = mem_val(m_a);
                    mem_ready = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if (mem_read && mem_write) begin
            bad++;
            $display("FAIL mem_exclusive got read=1 write=1 exp at most one");
        end
    end

    // Issues one cache request from a negedge and waits for its ack; cyc counts negedges until the ack.
    task automatic cache_op(input bit wr, input logic [27:0] a, input logic [127:0] d,
                            output logic [127:0] rd, output int cyc);
        cache_mem_read = !wr;
        cache_mem_write = wr;
        cache_mem_addr = a;
        cache_mem_wdata = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cache_mem_ready && cyc < 300);
        rd = cache_mem_rdata;
        if (!cache_mem_ready) begin
            total++;
            bad++;
            $display("FAIL cache_op_timeout got no ready exp ready within 300 cycles addr=%h", a);
        end else if (wr) model_write(a, d);
        cache_mem_read = 1'b0;
        cache_mem_write = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while ((exp_q.size() != 0 || mem_write || mem_read) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) begin
            total++;
            bad++;
            $display("FAIL %s_drain_timeout got pending=%0d exp 0", tag, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        repeat (3) @(negedge clk);
        total += 3;
        if (cache_mem_ready !== 1'b0 || cache_mem_rdata !== '0) begin
            bad++;
            $display("FAIL reset_cache got ready=%b rdata=%h exp 0/0", cache_mem_ready, cache_mem_rdata);
        end
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_req got read=%b write=%b exp 0/0", mem_read, mem_write);
        end
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata);
        end
        proc_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_accept();
        logic [127:0] rd;
        int cyc, w0;
        mem_lat = 2;
        w0 = n_wr_done;
        cache_op(1'b1, 28'h0000010, {16{8'hA5}}, rd, cyc);
        total += 2;
        if (cyc != 1) begin
            bad++;
            $display("FAIL write_latency got %0d exp 1", cyc);
        end
        if (mem_write !== 1'b0) begin
            bad++;
            $display("FAIL write_early_drain got mem_write=%b exp 0", mem_write);
        end
        wait_drain("write_accept");
        total++;
        if (n_wr_done != w0 + 1 || last_wr_a !== 28'h0000010 || last_wr_d !== {16{8'hA5}}) begin
            bad++;
            $display("FAIL write_drain got n=%0d addr=%h data=%h exp n=%0d addr=0000010 data=a5..a5", n_wr_done - w0, last_wr_a, last_wr_d, 1);
        end
    endtask

    task automatic test_read_after_write();
        logic [127:0] rd, d;
        int cyc, r0;
        mem_lat = 20;
        d = 128'h12345678_9abcdef0_0fedcba9_87654321;
        cache_op(1'b1, 28'h0000020, d, rd, cyc);
        r0 = n_rd_req;
        cache_op(1'b0, 28'h0000020, '0, rd, cyc);
        total += 3;
        if (cyc != 2) begin
            bad++;
            $display("FAIL raw_latency got %0d exp 2 (one RESP cycle then IDLE hit)", cyc);
        end
        if (rd !== d) begin
            bad++;
            $display("FAIL raw_data got %h exp %h", rd, d);
        end
        if (n_rd_req != r0) begin
            bad++;
            $display("FAIL raw_no_mem_read got %0d reads exp 0", n_rd_req - r0);
        end
        wait_drain("raw");
    endtask

    task automatic test_coalesce();
        logic [127:0] rd, x, y;
        int cyc, w0;
        mem_lat = 2;
        x = {4{$urandom}};
        y = ~x;
        w0 = n_wr_done;
        cache_op(1'b1, 28'h0000030, x, rd, cyc);
        cache_op(1'b1, 28'h0000030, y, rd, cyc);
        wait_drain("coalesce");
        total++;
        if (n_wr_done != w0 + 1 || last_wr_d !== y) begin
            bad++;
            $display("FAIL coalesce got writes=%0d data=%h exp writes=1 data=%h", n_wr_done - w0, last_wr_d, y);
        end
    endtask

    task automatic test_full_stall();
        logic [127:0] rd;
        int cyc, w0;
        mem_lat = 3;
        w0 = n_wr_done;
        for (int i = 0; i < 4; i++) cache_op(1'b1, 28'h0000040 + 28'(i), {4{$urandom}}, rd, cyc);
        total += 3;
        if (n_wr_done != w0) begin
            bad++;
            $display("FAIL full_fill got writes=%0d exp 0", n_wr_done - w0);
        end
        cache_op(1'b1, 28'h0000050, {4{$urandom}}, rd, cyc);
        if (n_wr_done != w0 + 1 || last_wr_a !== 28'h0000040) begin
            bad++;
            $display("FAIL full_head_first got writes=%0d addr=%h exp writes=1 addr=0000040", n_wr_done - w0, last_wr_a);
        end
        if (cyc > mem_lat + 4) begin
            bad++;
            $display("FAIL full_ack_latency got %0d exp <= %0d", cyc, mem_lat + 4);
        end
        wait_drain("full");
        total++;
        if (n_wr_done != w0 + 5 || last_wr_a !== 28'h0000050) begin
            bad++;
            $display("FAIL full_drain got writes=%0d last=%h exp writes=5 last=0000050", n_wr_done - w0, last_wr_a);
        end
    endtask

    task automatic test_read_priority();
        logic [127:0] rd, exp;
        int cyc, w0, wq, r0;
        mem_lat = 6;
        w0 = n_wr_done;
        cache_op(1'b1, 28'h0000070, {4{$urandom}}, rd, cyc);
        cache_op(1'b1, 28'h0000071, {4{$urandom}}, rd, cyc);
        wq = n_wr_req;
        r0 = n_rd_req;
        exp = model_read(28'h0000060);
        cache_op(1'b0, 28'h0000060, '0, rd, cyc);
        total += 3;
        if (n_wr_req != wq || n_rd_req != r0 + 1) begin
            bad++;
            $display("FAIL prio_order got wr_req=%0d rd_req=%0d exp 0/1", n_wr_req - wq, n_rd_req - r0);
        end
        if (rd !== exp) begin
            bad++;
            $display("FAIL prio_data got %h exp %h", rd, exp);
        end
        wait_drain("prio");
        if (n_wr_done != w0 + 2) begin
            bad++;
            $display("FAIL prio_resume got writes=%0d exp 2", n_wr_done - w0);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [127:0] rd, exp;
        int cyc, c, wq, r0;
        mem_lat = 30;
        cache_op(1'b1, 28'h0000080, {4{$urandom}}, rd, cyc);
        c = 0;
        while (!mem_write && c < 20) begin
            @(negedge clk);
            c++;
        end
        total += 4;
        if (!mem_write) begin
            bad++;
            $display("FAIL rst_drain_start got mem_write=0 exp 1");
        end
        proc_reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        if ({cache_mem_ready, mem_read, mem_write} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0 || cache_mem_rdata !== '0) begin
            bad++;
            $display("FAIL rst_outputs got rdy=%b rd=%b wr=%b addr=%h exp all 0", cache_mem_ready, mem_read, mem_write, mem_addr);
        end
        proc_reset = 1'b0;
        wq = n_wr_req;
        repeat (5) @(negedge clk);
        if (n_wr_req != wq) begin
            bad++;
            $display("FAIL rst_no_drain got %0d writes exp 0", n_wr_req - wq);
        end
        mem_lat = 2;
        r0 = n_rd_req;
        exp = model_read(28'h0000080);
        cache_op(1'b0, 28'h0000080, '0, rd, cyc);
        if (n_rd_req != r0 + 1 || rd !== exp) begin
            bad++;
            $display("FAIL rst_read_mem got reads=%0d data=%h exp reads=1 data=%h", n_rd_req - r0, rd, exp);
        end
    endtask

    task automatic test_random();
        logic [127:0] rd, d, exp;
        logic [27:0] a;
        int cyc;
        mem_lat = -1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = 28'h0000100 + 28'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                shadow[a] = d;
                cache_op(1'b1, a, d, rd, cyc);
            end else begin
                exp = model_read(a);
                cache_op(1'b0, a, '0, rd, cyc);
                total++;
                if (rd !== exp) begin
                    bad++;
                    $display("FAIL rand_read addr=%h got %h exp %h", a, rd, exp);
                end
            end
        end
        wait_drain("random");
        foreach (shadow[k]) begin
            total++;
            if (mem_val(k) !== shadow[k]) begin
                bad++;
                $display("FAIL rand_final addr=%h got %h exp %h", k, mem_val(k), shadow[k]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_accept();
        test_read_after_write();
        test_coalesce();
        test_full_stall();
        test_read_priority();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before 2ms");
        $fatal(1, "watchdog");
    end
endmodule
